// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg
//   Shared types for the core's AXI4-Lite endpoints.
//   axi_resp_t        : AXI response codes used on BRESP/RRESP.
//   axil_sram_state_t : state register type of the AXI-Lite SRAM slave.
//   mask_strb()       : gates a byte-strobe vector with a qualifying condition.
package hsv_core_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  typedef logic [1:0] axil_sram_state_t;

  // Byte-lane write enables: nothing is written unless the access is qualified.
  function automatic logic [3:0] mask_strb(input logic [3:0] strb, input logic ok);
    return ok ? strb : 4'b0000;
  endfunction

endpackage

// File: rtl/hsv_axil_sram_slave_if.sv
// hsv_axil_sram_slave_if
//   AXI4-Lite channel bundle between the interconnect (master) and the SRAM
//   endpoint (slave).
//   AW: s_awvalid/s_awready/s_awaddr     W: s_wvalid/s_wready/s_wdata/s_wstrb
//   B : s_bvalid/s_bready/s_bresp        AR: s_arvalid/s_arready/s_araddr
//   R : s_rvalid/s_rready/s_rdata/s_rresp
interface hsv_axil_sram_slave_if;

  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready,
           s_rvalid, s_rdata, s_rresp
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready,
           s_rvalid, s_rdata, s_rresp
  );

endinterface

// File: rtl/hsv_axil_sram_array.sv
// hsv_axil_sram_array
//   Single-port 32-bit SRAM with four byte-lane write enables and a registered
//   read port (1-cycle latency). The read register holds its value whenever
//   no read is issued. Contents are not reset; only the read register is.
//   clk    : clock               rst_n : async active-low reset (read register)
//   re     : read enable         we    : byte-lane write enables
//   addr   : word index          wdata : write word
//   rdata  : registered read word
module hsv_axil_sram_array #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rdata_r;

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read port; holds the last word while no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/hsv_axil_sram_slave.sv
// hsv_axil_sram_slave
//   AXI4-Lite responder backed by a byte-enabled single-port SRAM. Serves one
//   transaction at a time (IDLE -> WRESP | RRESP -> IDLE). A write is accepted
//   only when AW and W are both valid, in the same cycle; write/read conflicts
//   are resolved round-robin (the loser of the last conflict wins the next).
//   Loads return full words; sub-word selection is done by the requester.
//   Word index = ((addr - BASE_ADDR) >> 2) mod DEPTH_WORDS.
//   Optional feature macro: HSV_AXIL_SRAM_RANGE_CHECK_EN -- out-of-window
//   accesses return SLVERR, writes are suppressed and reads return 0.
//   Without it, addresses alias into the array and responses are always OKAY.
//   Ports:
//     clk_core   : core clock (posedge)
//     rst_core_n : asynchronous active-low reset
//     bus        : AXI4-Lite slave modport (hsv_axil_sram_slave_if.slave)
module hsv_axil_sram_slave
  import hsv_core_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                         clk_core,
  input  logic                         rst_core_n,
  hsv_axil_sram_slave_if.slave         bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRESP = 2'b01;
  localparam logic [1:0] ST_RRESP = 2'b10;

  axil_sram_state_t state_r;
  logic             prio_rd_r;   // 1: read wins the next write/read conflict
  logic             bvalid_r;
  axi_resp_t        bresp_r;
  logic             rvalid_r;
  axi_resp_t        rresp_r;

  logic             wr_elig_s;
  logic             rd_elig_s;
  logic             grant_wr_s;
  logic             grant_rd_s;
  logic [31:0]      wr_off_s;
  logic [31:0]      rd_off_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic [3:0]       ram_we_s;
  logic             ram_re_s;
  logic [AW-1:0]    ram_addr_s;
  logic [31:0]      ram_q_s;

  // Offsets from the window base; the index keeps only the in-array word bits,
  // which gives the modulo-DEPTH aliasing for free.
  assign wr_off_s = bus.s_awaddr - BASE_ADDR;
  assign rd_off_s = bus.s_araddr - BASE_ADDR;
  assign wr_idx_s = AW'(wr_off_s >> 2);
  assign rd_idx_s = AW'(rd_off_s >> 2);

`ifdef HSV_AXIL_SRAM_RANGE_CHECK_EN
  // In range when at/above the base and the offset fits inside the array.
  assign wr_ok_s = (bus.s_awaddr >= BASE_ADDR) && ((wr_off_s >> (AW + 2)) == 32'd0);
  assign rd_ok_s = (bus.s_araddr >= BASE_ADDR) && ((rd_off_s >> (AW + 2)) == 32'd0);
`else
  assign wr_ok_s = 1'b1;
  assign rd_ok_s = 1'b1;
`endif

  // Eligibility and round-robin grant; only evaluated while idle.
  always_comb begin
    wr_elig_s  = (state_r == ST_IDLE) && bus.s_awvalid && bus.s_wvalid;
    rd_elig_s  = (state_r == ST_IDLE) && bus.s_arvalid;
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if (wr_elig_s && rd_elig_s) begin
      grant_rd_s = prio_rd_r;
      grant_wr_s = !prio_rd_r;
    end else if (wr_elig_s) begin
      grant_wr_s = 1'b1;
    end else if (rd_elig_s) begin
      grant_rd_s = 1'b1;
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
  end

  assign bus.s_awready = grant_wr_s;
  assign bus.s_wready  = grant_wr_s;
  assign bus.s_arready = grant_rd_s;

  assign ram_we_s   = mask_strb(bus.s_wstrb, grant_wr_s && wr_ok_s);
  assign ram_re_s   = grant_rd_s && rd_ok_s;
  assign ram_addr_s = grant_wr_s ? wr_idx_s : rd_idx_s;

  hsv_axil_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk_core),
    .rst_n (rst_core_n),
    .re    (ram_re_s),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (bus.s_wdata),
    .rdata (ram_q_s)
  );

  // Transaction FSM with registered response channels.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_r  <= ST_IDLE;
      bvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
      rvalid_r <= 1'b0;
      rresp_r  <= RESP_OKAY;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_wr_s) begin
            state_r  <= ST_WRESP;
            bvalid_r <= 1'b1;
            bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
          end else if (grant_rd_s) begin
            state_r  <= ST_RRESP;
            rvalid_r <= 1'b1;
            rresp_r  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_WRESP: begin
          if (bus.s_bready) begin
            state_r  <= ST_IDLE;
            bvalid_r <= 1'b0;
          end else begin
            state_r  <= ST_WRESP;
          end
        end
        ST_RRESP: begin
          if (bus.s_rready) begin
            state_r  <= ST_IDLE;
            rvalid_r <= 1'b0;
          end else begin
            state_r  <= ST_RRESP;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          bvalid_r <= 1'b0;
          rvalid_r <= 1'b0;
        end
      endcase
    end
  end

  // Round-robin pointer: after a conflict the losing side gets priority.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      prio_rd_r <= 1'b0;
    end else if (wr_elig_s && rd_elig_s) begin
      prio_rd_r <= grant_wr_s;
    end else begin
      prio_rd_r <= prio_rd_r;
    end
  end

  assign bus.s_bvalid = bvalid_r;
  assign bus.s_bresp  = bresp_r;
  assign bus.s_rvalid = rvalid_r;
  assign bus.s_rresp  = rresp_r;
  // Rejected reads present zero; the array register itself is left untouched.
  assign bus.s_rdata  = (rresp_r == RESP_SLVERR) ? 32'h0000_0000 : ram_q_s;

endmodule

// File: tb/tb_hsv_axil_sram_slave.sv
// tb_hsv_axil_sram_slave
//   Scoreboard bench: an accept tracker updates a word-array reference model
//   and queues expected B/R responses; an independent monitor pops and checks
//   them (value, latency, stability) whenever the DUT presents a response.
//   Honours HSV_AXIL_SRAM_RANGE_CHECK_EN the same way the design does.
module tb_hsv_axil_sram_slave;

  localparam logic [31:0] TB_BASE  = 32'h0000_0000;
  localparam int          TB_DEPTH = 4096;
  localparam logic [31:0] TB_SPAN  = 32'h0000_4000;   // 4 * TB_DEPTH bytes

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          cyc;
    bit          known;
  } exp_t;

  logic clk;
  logic rst_n;
  hsv_axil_sram_slave_if bus ();

  hsv_axil_sram_slave #(
    .DEPTH_WORDS (TB_DEPTH),
    .BASE_ADDR   (TB_BASE)
  ) dut (
    .clk_core   (clk),
    .rst_core_n (rst_n),
    .bus        (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int ready_mode = 0;   // 0: ready high, 1: random, 2: ready low

  logic [31:0] mdl_mem   [TB_DEPTH];
  bit          mdl_known [TB_DEPTH];
  exp_t        exp_b [$];
  exp_t        exp_r [$];
  byte         grant_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit mdl_ok(input logic [31:0] a);
`ifdef HSV_AXIL_SRAM_RANGE_CHECK_EN
    return (a - TB_BASE) < TB_SPAN;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int mdl_idx(input logic [31:0] a);
    return int'(((a - TB_BASE) >> 2) % TB_DEPTH);
  endfunction

  // Accept tracker: protocol invariants plus reference-model update on each accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.s_awvalid) chk("aw_needs_w", {31'd0, bus.s_awready & ~bus.s_wvalid}, 32'd0);
      if (bus.s_awvalid || bus.s_wvalid) chk("aw_w_same_cycle", {31'd0, bus.s_awready}, {31'd0, bus.s_wready});
      if (bus.s_bvalid || bus.s_rvalid)
        chk("no_accept_pending", {31'd0, bus.s_awready | bus.s_arready}, 32'd0);
      if (bus.s_awvalid && bus.s_wvalid && bus.s_arvalid)
        chk("single_grant", {31'd0, bus.s_awready & bus.s_arready}, 32'd0);
      if (bus.s_awvalid && bus.s_awready && bus.s_wvalid && bus.s_wready) begin
        exp_t e;
        int   k;
        k = mdl_idx(bus.s_awaddr);
        if (mdl_ok(bus.s_awaddr)) begin
          for (int i = 0; i < 4; i++)
            if (bus.s_wstrb[i]) mdl_mem[k][8*i +: 8] = bus.s_wdata[8*i +: 8];
          if (bus.s_wstrb == 4'hF) mdl_known[k] = 1'b1;
        end
        e.data = 32'd0; e.known = 1'b1; e.cyc = cycle;
        e.resp = mdl_ok(bus.s_awaddr) ? 2'b00 : 2'b10;
        exp_b.push_back(e);
        grant_q.push_back(8'h57);   // 'W'
      end
      if (bus.s_arvalid && bus.s_arready) begin
        exp_t e;
        int   k;
        k = mdl_idx(bus.s_araddr);
        e.cyc = cycle;
        if (mdl_ok(bus.s_araddr)) begin
          e.resp = 2'b00; e.data = mdl_mem[k]; e.known = mdl_known[k];
        end else begin
          e.resp = 2'b10; e.data = 32'd0; e.known = 1'b1;
        end
        exp_r.push_back(e);
        grant_q.push_back(8'h52);   // 'R'
      end
    end
  end

  // Response monitor: pops expectations, checks latency, value and hold-stability.
  bit          b_act = 1'b0;
  logic [1:0]  b_hold;
  bit          r_act = 1'b0;
  logic [1:0]  r_hold_resp;
  logic [31:0] r_hold_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_act = 1'b0;
      r_act = 1'b0;
    end else begin
      if (bus.s_bvalid) begin
        if (!b_act) begin
          chk("b_has_expectation", {31'd0, exp_b.size() != 0}, 32'd1);
          if (exp_b.size() != 0) begin
            exp_t e;
            e = exp_b.pop_front();
            chk("bresp", {30'd0, bus.s_bresp}, {30'd0, e.resp});
            chk("bvalid_latency", cycle, e.cyc + 1);
          end
          b_act  = 1'b1;
          b_hold = bus.s_bresp;
        end else begin
          chk("bresp_stable", {30'd0, bus.s_bresp}, {30'd0, b_hold});
        end
        if (bus.s_bready) b_act = 1'b0;
      end else begin
        chk("bvalid_dropped", {31'd0, b_act}, 32'd0);
        b_act = 1'b0;
      end
      if (bus.s_rvalid) begin
        if (!r_act) begin
          chk("r_has_expectation", {31'd0, exp_r.size() != 0}, 32'd1);
          if (exp_r.size() != 0) begin
            exp_t e;
            e = exp_r.pop_front();
            chk("rresp", {30'd0, bus.s_rresp}, {30'd0, e.resp});
            chk("rvalid_latency", cycle, e.cyc + 1);
            if (e.known) chk("rdata", bus.s_rdata, e.data);
          end
          r_act       = 1'b1;
          r_hold_resp = bus.s_rresp;
          r_hold_data = bus.s_rdata;
        end else begin
          chk("rresp_stable", {30'd0, bus.s_rresp}, {30'd0, r_hold_resp});
          chk("rdata_stable", bus.s_rdata, r_hold_data);
        end
        if (bus.s_rready) r_act = 1'b0;
      end else begin
        chk("rvalid_dropped", {31'd0, r_act}, 32'd0);
        r_act = 1'b0;
      end
    end
  end

  // Response-channel ready generator.
  initial begin
    bus.s_bready = 1'b0;
    bus.s_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       begin bus.s_bready = 1'b1; bus.s_rready = 1'b1; end
        1:       begin bus.s_bready = 1'($urandom_range(0, 1)); bus.s_rready = 1'($urandom_range(0, 1)); end
        default: begin bus.s_bready = 1'b0; bus.s_rready = 1'b0; end
      endcase
    end
  end

  // Present a write and/or read and hold each until accepted (bounded).
  task automatic issue(input bit dw, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input bit dr, input logic [31:0] ra);
    bit pend_w, pend_r, w_acc, r_acc;
    int n;
    if (dw) begin
      bus.s_awvalid = 1'b1; bus.s_awaddr = wa;
      bus.s_wvalid  = 1'b1; bus.s_wdata  = wd; bus.s_wstrb = ws;
    end
    if (dr) begin
      bus.s_arvalid = 1'b1; bus.s_araddr = ra;
    end
    pend_w = dw; pend_r = dr; n = 0;
    while ((pend_w || pend_r) && n < 200) begin
      @(negedge clk);
      w_acc = bus.s_awvalid && bus.s_awready;
      r_acc = bus.s_arvalid && bus.s_arready;
      @(posedge clk);
      #1;
      if (w_acc) begin bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; pend_w = 1'b0; end
      if (r_acc) begin bus.s_arvalid = 1'b0; pend_r = 1'b0; end
      n++;
    end
    chk("accept_within_bound", {31'd0, pend_w | pend_r}, 32'd0);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int sel;
    a   = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    sel = $urandom_range(0, 19);
    if (sel < 4)       a = a + 32'h0000_4000;
    else if (sel == 4) a = a + 32'h8001_0000;
    return a;
  endfunction

  initial begin
    bus.s_awvalid = 1'b0; bus.s_awaddr = 32'd0;
    bus.s_wvalid  = 1'b0; bus.s_wdata  = 32'd0; bus.s_wstrb = 4'd0;
    bus.s_arvalid = 1'b0; bus.s_araddr = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_bvalid", {31'd0, bus.s_bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.s_rvalid}, 32'd0);
    chk("rst_awready", {31'd0, bus.s_awready}, 32'd0);
    chk("rst_arready", {31'd0, bus.s_arready}, 32'd0);
    chk("rst_bresp", {30'd0, bus.s_bresp}, 32'd0);
    chk("rst_rresp", {30'd0, bus.s_rresp}, 32'd0);
    chk("rst_rdata", bus.s_rdata, 32'd0);
    @(posedge clk); #1;

    // Known contents for the words the random phase touches.
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 32'd0);

    // Full-word write then read back.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0);
    issue(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h10);
    // Single-lane store; read with non-zero low address bits.
    issue(1'b1, 32'h10, 32'hAAAA_AAAA, 4'b0100, 1'b0, 32'd0);
    issue(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h12);
    chk("lane_merge_model", mdl_mem[4], 32'hDEAA_BEEF);

    // AW presented alone for 5 cycles must not be accepted.
    bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h20;
    repeat (5) begin
      @(negedge clk);
      chk("aw_alone_wait", {31'd0, bus.s_awready}, 32'd0);
    end
    @(posedge clk); #1;
    issue(1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0, 32'd0);
    issue(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h20);

    // Two back-to-back conflicts: write first, then read (round-robin).
    grant_q.delete();
    issue(1'b1, 32'h24, 32'hCAFE_0001, 4'hF, 1'b1, 32'h24);
    issue(1'b1, 32'h28, 32'hCAFE_0002, 4'hF, 1'b1, 32'h24);
    chk("rr_grant_count", grant_q.size(), 32'd4);
    if (grant_q.size() == 4) begin
      chk("rr_first_conflict", {24'd0, grant_q[0]}, 32'h57);
      chk("rr_second_conflict", {24'd0, grant_q[2]}, 32'h52);
    end

    // Back-pressure on B, then on R, for 10+ cycles.
    ready_mode = 2;
    fork
      issue(1'b1, 32'h2C, 32'h0BAD_F00D, 4'hF, 1'b0, 32'd0);
      begin repeat (4) @(posedge clk); #2 bus.s_arvalid = 1'b1; bus.s_araddr = 32'h2C; end
    join
    repeat (10) @(posedge clk);
    ready_mode = 0;
    issue(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h2C);
    ready_mode = 2;
    issue(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h30);
    repeat (12) @(posedge clk);
    ready_mode = 0;

    // Address just past the array: SLVERR with range check, alias of word 0 otherwise.
    issue(1'b1, 32'h4000, 32'h5A5A_5A5A, 4'hF, 1'b0, 32'd0);
    issue(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h4000);
    issue(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h0);

    // Randomized traffic with random response back-pressure.
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      issue(kind != 1, rand_addr(), $urandom, 4'($urandom_range(0, 15)), kind != 0, rand_addr());
    end

    // Drain outstanding responses.
    ready_mode = 0;
    for (int i = 0; i < 50; i++) begin
      if (exp_b.size() == 0 && exp_r.size() == 0 && !b_act && !r_act) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    chk("drain_b", exp_b.size(), 32'd0);
    chk("drain_r", exp_r.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
